fetch_prefetch: RTL

Parametrised instruction-fetch stage with a prefetch queue between the PC/IM read and decode. Fetches one word per cycle from an asynchronous-read instruction memory into a DEPTH-entry FIFO. Decode consumes from the FIFO head with a valid/stall handshake. Branch redirect and interrupt both flush the queue and steer the PC. Address faults are tagged per entry rather than flagged globally.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/prefetch_fifo.sv | 62 ++++++
 rtl/fetch_prefetch.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: default address map, fetch-entry layout and FSM encoding.
package fetch_pkg;

    localparam logic [31:0] FETCH_IM_BASE = 32'h0000_3000;
    localparam logic [31:0] FETCH_EXC_VEC = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// Power-of-two circular queue with synchronous reset/flush; head is zero whenever the queue is empty.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            // Simultaneous push and pop leaves occupancy unchanged, even when full.
            if (push & ~pop)      cnt_d = cnt_q + 1'b1;
            else if (pop & ~push) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push & ~flush & ~reset) mem_q[wr_q] <= wdata;
    end

    assign valid = (cnt_q != '0);
    assign head  = valid ? mem_q[rd_q] : '0;
    assign count = cnt_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: PC, IM read, fault tagging and RUN/HALT control in front of a prefetch queue.
// Optional FETCH_BYPASS_EN presents an empty-queue fetch on the head outputs in the same cycle.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH   = 4,
    parameter int          IM_AW   = 12,
    parameter logic [31:0] IM_BASE = FETCH_IM_BASE,
    parameter logic [31:0] EXC_VEC = FETCH_EXC_VEC
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    input  logic                         int_req,
    input  logic                         stall_d,
    output logic [IM_AW-1:0]             im_addr,
    input  logic [31:0]                  im_data,
    output logic                         valid_d,
    output logic [31:0]                  instr_d,
    output logic [31:0]                  pc_d,
    output logic [31:0]                  pcadd4_d,
    output logic                         exc_d,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [32:0] IM_SPAN = 33'd4 << IM_AW;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   fpc_off;
    logic          fault;
    logic          flush;
    logic          fifo_valid;
    logic          bypass;
    logic          bypass_take;
    logic          pop;
    logic          fetch_ok;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  fetch_entry;
    fetch_entry_t  fifo_head;
    fetch_entry_t  head;

    assign fpc_off = fpc_q - IM_BASE;
    assign im_addr = fpc_off[IM_AW+1:2];
    assign fault   = (|fpc_q[1:0]) | (fpc_q < IM_BASE) | ({1'b0, fpc_off} >= IM_SPAN);

    // A faulting fetch carries a nop so decode never sees out-of-range IM data.
    assign fetch_entry = '{pc: fpc_q, instr: (fault ? 32'h0 : im_data), exc: fault};

    assign flush = int_req | redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign bypass = ~reset & ~fifo_valid & (state_q == RUN) & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign valid_d     = fifo_valid | bypass;
    assign head        = fifo_valid ? fifo_head : (bypass ? fetch_entry : '0);
    assign pop         = valid_d & ~stall_d;
    assign bypass_take = bypass & ~stall_d;
    assign fetch_ok    = (state_q == RUN) & ~flush & ((count < FULL) | pop);
    assign fifo_push   = fetch_ok & ~bypass_take;
    assign fifo_pop    = pop & fifo_valid & ~flush;

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        if (int_req) begin
            state_d = RUN;
            fpc_d   = EXC_VEC;
        end else if (redirect_valid) begin
            state_d = RUN;
            fpc_d   = redirect_pc;
        end else if (fetch_ok) begin
            // A fault parks the PC on the bad address until a redirect or interrupt.
            if (fault) state_d = HALT;
            else       fpc_d   = fpc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            fpc_q   <= IM_BASE;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fetch_entry),
        .head  (fifo_head),
        .valid (fifo_valid),
        .count (count)
    );

    assign pc_d     = head.pc;
    assign instr_d  = head.instr;
    assign exc_d    = head.exc;
    assign pcadd4_d = valid_d ? head.pc + 32'd4 : 32'h0;

endmodule
